// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit common-anode hex display driver with a frame-synchronous value swap.
// Define SEVSEG_LZB_EN to blank leading zeros (digit 0 is never blanked).

module seven_segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  // Active-low segments, bit 6 = g ... bit 0 = a.
  always_comb begin
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

module seven_segment_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int ON_CYCLES    = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                  i_clock,
  input  logic                  i_RESET,
  input  logic                  i_enable,
  input  logic [4*N_DIGITS-1:0] i_value,
  input  logic                  i_load,
  output logic                  o_ack,
  output logic [6:0]            o_seg,
  output logic [N_DIGITS-1:0]   o_dig,
  output logic                  o_frame
);

  localparam int MAX_CYCLES = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam int IW         = $clog2(N_DIGITS);

  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF    = 7'h7F;

  typedef enum logic {GUARD, ON} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  boundary;
  logic                  transfer;

  logic [4*N_DIGITS-1:0] shadow_q;
  logic [4*N_DIGITS-1:0] display_q;
  logic                  pending_q;

  logic [3:0]            cur_nibble;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   blank;

  logic [6:0]            seg_d;
  logic [N_DIGITS-1:0]   dig_d;
  logic                  frame_d;
  logic                  ack_d;

  // ---------------------------------------------------------------------------
  // Scan FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      state_q <= GUARD;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default on entry; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    boundary = 1'b0;
    if (!i_enable) begin
      state_d = GUARD;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        GUARD: begin
          if (cnt_q == GUARD_LAST) begin
            state_d = ON;
            cnt_d   = '0;
          end
        end
        ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = GUARD;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              boundary = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A disabled display is idle, so any cycle of it is a safe point to swap data.
  assign transfer = pending_q & (boundary | ~i_enable);

  // ---------------------------------------------------------------------------
  // Shadow / display registers
  // ---------------------------------------------------------------------------
  // NOTE: shadow and display are reset on purpose so a fresh board shows zeros
  // rather than power-up garbage; plain data storage would normally stay unreset.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      shadow_q  <= '0;
      display_q <= '0;
      pending_q <= 1'b0;
    end else begin
      if (transfer) display_q <= shadow_q;
      // A load on the swap edge wins: the old shadow moves, the new one stays pending.
      if (i_load) begin
        shadow_q  <= i_value;
        pending_q <= 1'b1;
      end else if (transfer) begin
        pending_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Decode and leading-zero blanking
  // ---------------------------------------------------------------------------
  assign cur_nibble = display_q[4*idx_q +: 4];

  seven_segment u_dec (
    .hex (cur_nibble),
    .seg (dec_seg)
  );

`ifdef SEVSEG_LZB_EN
  logic upper_zero;

  always_comb begin
    upper_zero = 1'b1;
    blank      = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (display_q[4*k +: 4] == 4'h0);
      blank[k]   = upper_zero;
    end
  end
`else
  assign blank = '0;
`endif

  // ---------------------------------------------------------------------------
  // Scan FSM: outputs (registered one cycle behind the state)
  // ---------------------------------------------------------------------------
  // Segments reload only during GUARD, so they are settled before the digit lights.
  always_comb begin
    dig_d   = '1;
    seg_d   = o_seg;
    frame_d = boundary;
    ack_d   = transfer;
    if (!i_enable) begin
      seg_d = SEG_OFF;
    end else if (state_q == GUARD) begin
      seg_d = blank[idx_q] ? SEG_OFF : dec_seg;
    end else begin
      dig_d[idx_q] = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      o_seg   <= SEG_OFF;
      o_dig   <= '1;
      o_ack   <= 1'b0;
      o_frame <= 1'b0;
    end else begin
      o_seg   <= seg_d;
      o_dig   <= dig_d;
      o_ack   <= ack_d;
      o_frame <= frame_d;
    end
  end

endmodule
